fft_out_collector: RTL and testbench
====================================

# fft_out_collector

Receive-side companion of the 16-point FFT core. It consumes the FFT's push/stall result stream (`out_push_F`/`out_real_F`/`out_imag_F`, back-pressured by `out_stall`) and assembles the 16 samples of each transform into one of two ping-pong frame banks, optionally undoing bit-reversed ordering. It then replays each complete frame, in natural bin order, on a valid/ready stream to downstream consumers. It sits directly between the FFT output and any spectrum post-processing.

## Interface
Parameters:
- `BITREV`, 1: 1 = push k is written to bin address bitrev4(k); 0 = written to address k.
- `SKID`, 2: pushes the producer may still issue after `in_stall` rises (registered producer output plus stall sampling).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserts immediately, deasserts synchronously to `clk`).
- `in_push`  in  1  sample valid from FFT.
- `in_real`  in  16  real part, two's complement.
- `in_imag`  in  16  imag part, two's complement.
- `in_stall`  out  1  registered back-pressure to FFT (drives its `out_stall`).
- `out_valid`  out  1  frame word valid.
- `out_ready`  in  1  downstream accepts word.
- `out_real`  out  16  bin real part.
- `out_imag`  out  16  bin imag part.
- `out_index`  out  4  bin number 0..15.
- `out_last`  out  1  high with bin 15.
- `overflow`  out  1  sticky: a push arrived with no free slot.

## Operation
- Two banks, each 16 x 32 bits (`{real, imag}`), each with a state: FREE, FILLING, or FULL.
- Write side:
  - Write pointer `wcnt` (0..15) and write-bank select `wb`.
  - On `in_push` while `wb` is FREE or FILLING: store at addr(wcnt), increment `wcnt`, mark bank FILLING.
  - On the 16th push: mark bank FULL, `wcnt` <- 0, toggle `wb`.
- Read side:
  - Read-bank select `rb` and read pointer `rcnt`.
  - While bank `rb` is FULL: `out_valid`=1 and outputs show entry `rcnt`.
  - On `out_valid && out_ready`: `rcnt`++. After `rcnt`=15 is accepted, bank -> FREE, `rcnt` <- 0, toggle `rb`.
- `in_stall`, registered: next-cycle `in_stall` = (bank `!wb` not FREE) && (`wcnt` + pushes-this-cycle >= 16 - SKID); also 1 if bank `wb` itself is FULL.
- Overflow: a push while bank `wb` is FULL is dropped, and `overflow` is set. It clears only on reset.
- Frames are emitted strictly in arrival order. Data is passed through unscaled, with no arithmetic.

## Timing
- Reset values: `in_stall`=0, `out_valid`=0, `out_real`=`out_imag`=0, `out_index`=0, `out_last`=0, `overflow`=0. Both banks FREE, `wb`=`rb`=0, all pointers 0. Bank contents are don't-care.
- Latency: if the 16th push is sampled at edge E, `out_valid`=1 and bin 0 are visible immediately after E (one cycle).
- Output words stay stable while `out_valid && !out_ready`. One word is transferred per cycle at full rate, so a frame drains in 16 cycles minimum.
- Simultaneous events:
  - A write completing bank A and a read freeing bank B at the same edge are both honoured.
  - Stall is computed from post-edge state, so a freed bank deasserts `in_stall` the following cycle.
- Bank switch-over: after bin 15 of bank A is accepted with bank B FULL, bin 0 of bank B is presented on the next cycle with no bubble.
- A reset asserted mid-frame discards all partial and full frames. `out_valid` drops asynchronously.

## Structure
- Shared FFT package holds:
  - `FFT_N`=16 and `FFT_LOG2N`=4.
  - The sample word type `{real[15:0], imag[15:0]}`.
  - A `bitrev4` function, shared with the control state machine.
- One natural sub-module, `frame_bank`: a 16x32 register array with one write port and one combinational read port, instantiated twice.
- The bank-state FSM and the pointers live in the top level.

## Test plan
- **Single frame, BITREV=0:** push k=0..15 with real=k, imag=-k, `out_ready`=1. Expect bins 0..15 with real=index and imag=-index, `out_last` on index 15, `out_valid` starting one cycle after the 16th push.
- **BITREV=1:** push real=k for k=0..15. Expect bin 1 real=8, bin 2 real=4, bin 3 real=12, bin 15 real=15.
- **Back-pressure:**
  - Hold `out_ready`=0 and push 3 frames back-to-back, honouring `in_stall` with a 2-cycle response.
  - Expect `in_stall`=1 after push 30 of the 32 that fill both banks, and `overflow`=0.
  - Release `out_ready`. Expect frames 0, 1, 2 in order, intact.
- **Overflow:** with both banks FULL, force 1 push. Expect `overflow`=1 and the data dropped, with frame contents unchanged.
- **Stall during output:** toggle `out_ready` randomly (50%). Every word must stay stable while not accepted, and exactly 16 words must be accepted per frame.
- **Mid-frame reset:** assert `reset`=0 after push 7 of a frame and while a frame is draining. Expect all outputs at reset values immediately. After release, a new 16-push frame emits correctly starting from bin 0.

Source files
------------

// File: rtl/fft_out_collector_pkg.sv
// Shared definitions for the 16-point FFT result path: transform size,
// the packed complex sample word, bank occupancy states, bit reversal.
package fft_out_collector_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG2N = 4;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_st_t;

  // Mirror the bits of a 4-bit bin number (push order -> natural order).
  function automatic logic [FFT_LOG2N-1:0] bitrev4(input logic [FFT_LOG2N-1:0] k);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      r[i] = k[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_out_collector_bank.sv
// One frame bank: 16 complex samples, synchronous write, combinational read.
module frame_bank
  import fft_out_collector_pkg::*;
(
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [FFT_LOG2N-1:0] i_waddr,
  input  sample_t              i_wdata,
  input  logic [FFT_LOG2N-1:0] i_raddr,
  output sample_t              o_rdata
);

  sample_t r_mem [FFT_N];

  // Sample storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_out_collector.sv
// Collects the FFT push/stall result stream into two ping-pong frame banks
// and replays each complete frame in natural bin order on valid/ready.
module fft_out_collector
  import fft_out_collector_pkg::*;
#(
  parameter int BITREV = 1,
  parameter int SKID   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_push,
  input  logic signed [15:0] in_real,
  input  logic signed [15:0] in_imag,
  output logic               in_stall,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] out_real,
  output logic signed [15:0] out_imag,
  output logic [3:0]         out_index,
  output logic               out_last,
  output logic               overflow
);

  bank_st_t             r_st [2];
  logic                 r_wb;
  logic                 r_rb;
  logic [FFT_LOG2N-1:0] r_wcnt;
  logic [FFT_LOG2N-1:0] r_rcnt;
  logic                 r_stall;
  logic                 r_ovf;

  bank_st_t             w_st_n [2];
  logic                 w_wb_n;
  logic                 w_rb_n;
  logic [FFT_LOG2N-1:0] w_wcnt_n;
  logic [FFT_LOG2N-1:0] w_rcnt_n;
  logic                 w_stall_n;
  logic                 w_ovf_n;
  logic                 w_we;
  logic                 w_valid;
  logic [FFT_LOG2N-1:0] w_waddr;
  sample_t              w_wdata;
  sample_t              w_rd [2];
  sample_t              w_word;

  assign w_wdata = {in_real, in_imag};
  assign w_waddr = (BITREV != 0) ? bitrev4(r_wcnt) : r_wcnt;
  assign w_valid = (r_st[r_rb] == BANK_FULL);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    frame_bank u_bank (
      .clk     (clk),
      .i_we    (w_we && (r_wb == 1'(b))),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_raddr (r_rcnt),
      .o_rdata (w_rd[b])
    );
  end

  // Bank states, pointers, stall and sticky overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_st[0] <= BANK_FREE;
      r_st[1] <= BANK_FREE;
      r_wb    <= 1'b0;
      r_rb    <= 1'b0;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_st    <= w_st_n;
      r_wb    <= w_wb_n;
      r_rb    <= w_rb_n;
      r_wcnt  <= w_wcnt_n;
      r_rcnt  <= w_rcnt_n;
      r_stall <= w_stall_n;
      r_ovf   <= w_ovf_n;
    end
  end

  // Next state: write side fills bank wb, read side drains bank rb; they
  // never touch the same bank in one cycle because writes skip FULL banks.
  always_comb begin
    w_st_n   = r_st;
    w_wb_n   = r_wb;
    w_rb_n   = r_rb;
    w_wcnt_n = r_wcnt;
    w_rcnt_n = r_rcnt;
    w_ovf_n  = r_ovf;
    w_we     = 1'b0;
    if (in_push) begin
      if (r_st[r_wb] == BANK_FULL) begin
        w_ovf_n = 1'b1;
      end else begin
        w_we = 1'b1;
        if (r_wcnt == FFT_LOG2N'(FFT_N - 1)) begin
          w_st_n[r_wb] = BANK_FULL;
          w_wcnt_n     = '0;
          w_wb_n       = ~r_wb;
        end else begin
          w_st_n[r_wb] = BANK_FILLING;
          w_wcnt_n     = r_wcnt + 1'b1;
        end
      end
    end
    if (w_valid && out_ready) begin
      if (r_rcnt == FFT_LOG2N'(FFT_N - 1)) begin
        w_st_n[r_rb] = BANK_FREE;
        w_rcnt_n     = '0;
        w_rb_n       = ~r_rb;
      end else begin
        w_rcnt_n = r_rcnt + 1'b1;
      end
    end
    // Post-edge view: stop the producer while its in-flight pushes still fit.
    w_stall_n = ((w_st_n[~w_wb_n] != BANK_FREE) &&
                 (w_wcnt_n >= FFT_LOG2N'(FFT_N - SKID))) ||
                (w_st_n[w_wb_n] == BANK_FULL);
  end

  // Output words; data is masked to zero whenever nothing is being offered.
  always_comb begin
    w_word    = w_rd[r_rb];
    out_valid = w_valid;
    out_real  = w_valid ? w_word.re : '0;
    out_imag  = w_valid ? w_word.im : '0;
    out_index = w_valid ? r_rcnt : '0;
    out_last  = w_valid && (r_rcnt == FFT_LOG2N'(FFT_N - 1));
    in_stall  = r_stall;
    overflow  = r_ovf;
  end

endmodule

// File: tb/tb_fft_out_collector.sv
// Bench for fft_out_collector: two instances (natural and bit-reversed
// write order) share one stimulus stream and are compared every cycle
// against a frame-queue reference model.
module tb_fft_out_collector;

  localparam int SKID = 2;

  typedef logic [16*32-1:0] frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_push;
  logic [15:0] in_real;
  logic [15:0] in_imag;
  logic        out_ready;

  logic        stall0, valid0, last0, ovf0;
  logic        stall1, valid1, last1, ovf1;
  logic [15:0] real0, imag0, real1, imag1;
  logic [3:0]  idx0, idx1;

  always #5 clk = ~clk;

  fft_out_collector #(.BITREV(0), .SKID(SKID)) u_dut0 (
    .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real),
    .in_imag(in_imag), .in_stall(stall0), .out_valid(valid0),
    .out_ready(out_ready), .out_real(real0), .out_imag(imag0),
    .out_index(idx0), .out_last(last0), .overflow(ovf0)
  );

  fft_out_collector #(.BITREV(1), .SKID(SKID)) u_dut1 (
    .clk(clk), .reset(reset), .in_push(in_push), .in_real(in_real),
    .in_imag(in_imag), .in_stall(stall1), .out_valid(valid1),
    .out_ready(out_ready), .out_real(real1), .out_imag(imag1),
    .out_index(idx1), .out_last(last1), .overflow(ovf1)
  );

  // reference model state
  frame_t      frames[$];
  logic [31:0] part[$];
  logic [31:0] src[$];
  int          rpos;
  bit          m_ovf;
  int          n_acc;
  bit          sh0, sh1, sh2;
  logic [15:0] rec0 [16];
  logic [15:0] rec1 [16];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int brev4(input int k);
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction

  function automatic bit exp_stall();
    return (frames.size() == 2) || (frames.size() >= 1 && part.size() >= 16 - SKID);
  endfunction

  task automatic check_dut(input int d, input logic v, input logic st, input logic ov,
                           input logic [15:0] re, input logic [15:0] im,
                           input logic [3:0] idx, input logic lst);
    string  p;
    frame_t f;
    int     pos;
    logic [31:0] w;
    p = (d == 0) ? "nat" : "rev";
    chk({p, "_valid"}, 32'(v), 32'(frames.size() > 0));
    chk({p, "_stall"}, 32'(st), 32'(exp_stall()));
    chk({p, "_ovf"}, 32'(ov), 32'(m_ovf));
    if (frames.size() > 0) begin
      f   = frames[0];
      pos = (d == 0) ? rpos : brev4(rpos);
      w   = f[pos*32 +: 32];
      chk({p, "_real"}, 32'(re), 32'(w[31:16]));
      chk({p, "_imag"}, 32'(im), 32'(w[15:0]));
      chk({p, "_index"}, 32'(idx), 32'(rpos));
      chk({p, "_last"}, 32'(lst), 32'(rpos == 15));
    end
  endtask

  // rmode: 0 = ready low, 1 = ready high, 2 = random ready
  task automatic run(input int ncyc, input int rmode, input bit force_push, input bit track30);
    for (int c = 0; c < ncyc; c++) begin
      bit          do_push, drop, acc;
      logic [31:0] smp;
      frame_t      f;
      smp     = 32'h0;
      do_push = (src.size() > 0) && (force_push || !sh2);
      if (do_push) smp = src.pop_front();
      in_push   = do_push;
      in_real   = smp[31:16];
      in_imag   = smp[15:0];
      out_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
      drop = do_push && (frames.size() == 2);
      acc  = out_ready && (frames.size() > 0);
      @(posedge clk);
      #1;
      if (acc) begin
        rpos++;
        if (rpos == 16) begin
          void'(frames.pop_front());
          rpos = 0;
        end
      end
      if (drop) begin
        m_ovf = 1'b1;
      end else if (do_push) begin
        part.push_back(smp);
        n_acc++;
        if (part.size() == 16) begin
          for (int i = 0; i < 16; i++) f[i*32 +: 32] = part[i];
          frames.push_back(f);
          part.delete();
        end
        if (track30 && n_acc == 30) chk("stall_after_push30", 32'(stall0), 32'd1);
      end
      check_dut(0, valid0, stall0, ovf0, real0, imag0, idx0, last0);
      check_dut(1, valid1, stall1, ovf1, real1, imag1, idx1, last1);
      if (valid0) rec0[idx0] = real0;
      if (valid1) rec1[idx1] = real1;
      sh2 = sh1;
      sh1 = sh0;
      sh0 = stall0;
    end
    in_push = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset   = 1'b0;
    in_push = 1'b0;
    #1;
    chk({tag, "_valid"}, 32'(valid0), 32'd0);
    chk({tag, "_valid_rev"}, 32'(valid1), 32'd0);
    chk({tag, "_stall"}, 32'(stall0), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf0), 32'd0);
    chk({tag, "_real"}, 32'(real0), 32'd0);
    chk({tag, "_imag"}, 32'(imag0), 32'd0);
    chk({tag, "_index"}, 32'(idx0), 32'd0);
    chk({tag, "_last"}, 32'(last0), 32'd0);
    chk({tag, "_real_rev"}, 32'(real1), 32'd0);
    frames.delete();
    part.delete();
    src.delete();
    rpos  = 0;
    m_ovf = 1'b0;
    sh0 = 1'b0; sh1 = 1'b0; sh2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic add_random(input int n);
    for (int i = 0; i < n; i++) src.push_back($urandom);
  endtask

  initial begin
    reset     = 1'b1;
    in_push   = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b0;
    #2;
    do_reset("reset");

    // single frame, real = k, imag = -k
    for (int k = 0; k < 16; k++) src.push_back({16'(k), 16'(-k)});
    n_acc = 0;
    run(40, 1, 1'b0, 1'b0);
    chk("nat_bin7", 32'(rec0[7]), 32'd7);
    chk("nat_bin15", 32'(rec0[15]), 32'd15);
    chk("rev_bin1", 32'(rec1[1]), 32'd8);
    chk("rev_bin2", 32'(rec1[2]), 32'd4);
    chk("rev_bin3", 32'(rec1[3]), 32'd12);
    chk("rev_bin15", 32'(rec1[15]), 32'd15);

    // back-pressure: three frames offered with the consumer stalled
    add_random(48);
    n_acc = 0;
    run(60, 0, 1'b0, 1'b1);
    chk("no_ovf_after_fill", 32'(ovf0), 32'd0);

    // forced push into two full banks is dropped
    run(1, 0, 1'b1, 1'b0);
    chk("ovf_set_nat", 32'(ovf0), 32'd1);
    chk("ovf_set_rev", 32'(ovf1), 32'd1);
    add_random(1);
    run(250, 2, 1'b0, 1'b0);

    // random consumer stalls over several frames
    add_random(80);
    run(400, 2, 1'b0, 1'b0);

    // reset with one frame draining and the next 7 pushes in
    add_random(23);
    run(30, 0, 1'b0, 1'b0);
    run(3, 1, 1'b0, 1'b0);
    do_reset("midrst");
    add_random(16);
    run(40, 1, 1'b0, 1'b0);
    chk("end_idle", 32'(valid0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
